// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg: shared widths, Q8.8 constants and controller state encoding
package sigmoid_pkg;
  localparam int DW = 16;
  localparam int DEPTH = 121;
  localparam int AW = 7;
  localparam int TIMEOUT = 15;
  localparam logic [DW-1:0] ONE = 16'h0100;
  localparam logic [DW-1:0] SAT_LO = 16'hFA00;
  localparam logic [DW-1:0] SAT_HI = 16'h0600;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, ISSUE, WAIT} state_t;
endpackage

// File: rtl/sigmoid_ctrl_if.sv
// sigmoid_ctrl_if: load stream, MAC input, activation output and sigmoid LUT port bundle
interface sigmoid_ctrl_if;
  import sigmoid_pkg::*;
  logic load_start;
  logic ld_valid;
  logic [DW-1:0] ld_data;
  logic ld_ready;
  logic loaded;
  logic mac_valid;
  logic [DW-1:0] mac_data;
  logic mac_ready;
  logic act_valid;
  logic [DW-1:0] act_data;
  logic act_ready;
  logic timeout_err;
  logic sig_we;
  logic [AW-1:0] sig_addr;
  logic [DW-1:0] sig_d;
  logic sig_done;
  logic [DW-1:0] sig_in;
  logic sig_ready;
  logic [DW-1:0] sig_out;
  modport master (
    input load_start, ld_valid, ld_data, mac_valid, mac_data, act_ready, sig_ready, sig_out,
    output ld_ready, loaded, mac_ready, act_valid, act_data, timeout_err,
    output sig_we, sig_addr, sig_d, sig_done, sig_in
  );
  modport slave (
    output load_start, ld_valid, ld_data, mac_valid, mac_data, act_ready, sig_ready, sig_out,
    input ld_ready, loaded, mac_ready, act_valid, act_data, timeout_err,
    input sig_we, sig_addr, sig_d, sig_done, sig_in
  );
endinterface

// File: rtl/sigmoid_ctrl.sv
// sigmoid_ctrl: loads the sigmoid LUT from a stream, then serialises MAC results into single lookups
module sigmoid_ctrl
  import sigmoid_pkg::*;
(
  input logic clk,
  input logic reset,
  sigmoid_ctrl_if.master bus
);
  state_t state;
  logic [AW-1:0] cnt;
  logic [3:0] tmr;
  assign bus.ld_ready = state == LOAD;
  assign bus.mac_ready = state == RUN && !bus.act_valid && !bus.load_start;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tmr <= '0;
      bus.loaded <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.sig_we <= 1'b0;
      bus.sig_addr <= '0;
      bus.sig_d <= '0;
      bus.sig_done <= 1'b0;
      bus.sig_in <= '0;
      bus.act_valid <= 1'b0;
      bus.act_data <= '0;
    end else begin
      bus.sig_we <= 1'b0;
      bus.sig_done <= 1'b0;
      if (bus.act_valid && bus.act_ready) bus.act_valid <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (bus.load_start) begin
            state <= LOAD;
            cnt <= '0;
            bus.loaded <= 1'b0;
          end else if (state == RUN && bus.mac_valid && bus.mac_ready) begin
            state <= ISSUE;
            bus.sig_done <= 1'b1;
            bus.sig_in <= bus.mac_data;
          end
        end
        LOAD: begin
          if (bus.ld_valid) begin
            bus.sig_we <= 1'b1;
            bus.sig_addr <= cnt;
            bus.sig_d <= bus.ld_data;
            cnt <= cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1)) begin
              bus.loaded <= 1'b1;
              state <= RUN;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          tmr <= 4'd1;
        end
        WAIT: begin
          if (bus.sig_ready) begin
            bus.act_valid <= 1'b1;
            bus.act_data <= bus.sig_out;
            state <= RUN;
          end else if (tmr == 4'(TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            state <= RUN;
          end else tmr <= tmr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sigmoid_ctrl.sv
// tb_sigmoid_ctrl: directed checks of sigmoid_ctrl against a behavioural sigmoid LUT block
module tb_sigmoid_ctrl;
  import sigmoid_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr_lut = 1'b0;
  logic stall = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] lut [0:127];
  sigmoid_ctrl_if bus();
  sigmoid_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [15:0] lut_val(input logic [15:0] x);
    int s;
    s = int'($signed(x));
    if (s >= 1536) return ONE;
    if (s <= -1536) return 16'h0000;
    return lut[((s + 1536) * 120) / 3072];
  endfunction

  always @(posedge clk) begin
    if (clr_lut) for (int i = 0; i < 128; i++) lut[i] <= 16'h0;
    else if (bus.sig_we === 1'b1) lut[bus.sig_addr] <= bus.sig_d;
    bus.sig_ready <= !reset && bus.sig_done === 1'b1 && !stall;
    if (bus.sig_done === 1'b1) bus.sig_out <= lut_val(bus.sig_in);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_load(input string tag, input bit gaps, input int abort_at);
    int beat, seen, addr_bad, gap_bad, early_bad, cyc;
    bit acc;
    beat = 0; seen = 0; addr_bad = 0; gap_bad = 0; early_bad = 0; cyc = 0; acc = 0;
    tick; bus.load_start = 1'b1;
    tick; bus.load_start = 1'b0;
    while (cyc < 1000) begin
      if (bus.sig_we) begin
        seen++;
        if (bus.sig_addr != 7'(seen - 1) || bus.sig_d != 16'(2 * (seen - 1))) addr_bad++;
      end
      if (bus.sig_we != acc) gap_bad++;
      if (seen == DEPTH) break;
      if (bus.loaded || bus.mac_ready) early_bad++;
      if (beat == abort_at) begin
        bus.ld_valid = 1'b0;
        reset = 1'b1;
        tick;
        chk({tag, "_abort"}, {bus.loaded, bus.sig_we, bus.ld_ready}, 3'b000);
        reset = 1'b0;
        return;
      end
      bus.ld_valid = !(gaps && cyc % 3 == 2);
      bus.ld_data = 16'(beat * 2);
      acc = bus.ld_valid && bus.ld_ready;
      if (acc) beat++;
      cyc++;
      tick;
    end
    bus.ld_valid = 1'b0;
    bus.mac_valid = 1'b0;
    chk({tag, "_we_count"}, seen, DEPTH);
    chk({tag, "_addr_order"}, addr_bad, 0);
    chk({tag, "_we_vs_beat"}, gap_bad, 0);
    chk({tag, "_early"}, early_bad, 0);
    chk({tag, "_loaded"}, bus.loaded, 1);
    tick;
    chk({tag, "_we_idle"}, bus.sig_we, 0);
  endtask

  task automatic lookup(input string tag, input logic [15:0] x, input logic [15:0] exp);
    int n;
    n = 0;
    while (!bus.mac_ready && n < 50) begin tick; n++; end
    bus.mac_valid = 1'b1; bus.mac_data = x; bus.act_ready = 1'b0;
    tick; bus.mac_valid = 1'b0;
    chk({tag, "_done"}, {bus.sig_done, bus.sig_we, bus.sig_in}, {2'b10, x});
    tick;
    chk({tag, "_early"}, bus.act_valid, 0);
    tick;
    chk(tag, {bus.act_valid, bus.act_data}, {1'b1, exp});
    bus.act_ready = 1'b1;
    tick; bus.act_ready = 1'b0;
    chk({tag, "_clr"}, {bus.act_valid, bus.mac_ready}, 2'b01);
  endtask

  initial begin
    logic [15:0] vin [4];
    logic [15:0] vexp [4];
    logic [15:0] got [4];
    int idx, ng, nacc, cyc, tbad;
    vin = '{16'h0000, 16'h0100, 16'hFF00, 16'h0200};
    vexp = '{16'h0078, 16'h008C, 16'h0064, 16'h00A0};
    bus.load_start = 0; bus.ld_valid = 0; bus.ld_data = 0;
    bus.mac_valid = 0; bus.mac_data = 0; bus.act_ready = 0;
    repeat (3) tick;
    chk("reset_ctl", {bus.sig_we, bus.sig_done, bus.act_valid, bus.loaded, bus.timeout_err,
                      bus.mac_ready, bus.ld_ready}, 7'b0);
    chk("reset_data", {bus.sig_addr, bus.sig_d, bus.act_data}, 39'b0);
    reset = 1'b0;

    do_load("load", 1'b0, -1);

    lookup("sat_hi", 16'h0700, 16'h0100);
    lookup("sat_lo", 16'hF800, 16'h0000);
    lookup("mid", 16'h0000, 16'h0078);

    idx = 0; ng = 0; nacc = 0;
    bus.act_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.mac_valid = idx < 4;
      bus.mac_data = vin[idx % 4];
      if (bus.mac_valid && bus.mac_ready) idx++;
      tick;
    end
    chk("stall_accepts", idx, 1);
    chk("stall_hold", {bus.act_valid, bus.act_data}, {1'b1, vexp[0]});
    bus.act_ready = 1'b1;
    cyc = 0;
    while (ng < 4 && cyc < 100) begin
      if (bus.act_valid) begin got[ng] = bus.act_data; ng++; end
      bus.mac_valid = idx < 4;
      bus.mac_data = vin[idx % 4];
      if (bus.mac_valid && bus.mac_ready) idx++;
      cyc++;
      tick;
    end
    bus.mac_valid = 1'b0; bus.act_ready = 1'b0;
    chk("stream_count", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("stream_%0d", i), got[i], vexp[i]);

    clr_lut = 1'b1; tick; clr_lut = 1'b0;
    do_load("gapload", 1'b1, -1);
    tbad = 0;
    for (int i = 0; i < DEPTH; i++) if (lut[i] !== 16'(2 * i)) tbad++;
    chk("gap_table", tbad, 0);
    lookup("gap_lookup", 16'h0100, 16'h008C);

    stall = 1'b1;
    bus.mac_valid = 1'b1; bus.mac_data = 16'h0200;
    tick; bus.mac_valid = 1'b0;
    chk("to_done", bus.sig_done, 1);
    repeat (14) tick;
    chk("to_before", bus.timeout_err, 0);
    tick;
    chk("to_set", {bus.timeout_err, bus.act_valid, bus.mac_ready}, 3'b101);
    stall = 1'b0;
    lookup("after_to", 16'hFF00, 16'h0064);
    chk("to_sticky", bus.timeout_err, 1);

    do_load("abort", 1'b0, 60);
    chk("abort_err_clr", bus.timeout_err, 0);
    bus.mac_valid = 1'b1; bus.mac_data = 16'h0700;
    nacc = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.mac_ready || bus.act_valid || bus.sig_done) nacc++;
      tick;
    end
    chk("abort_ignore_mac", nacc, 0);
    do_load("reload", 1'b0, -1);
    lookup("reload_lookup", 16'h0700, 16'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
